traffic_phase_ctrl: RTL and testbench



---
 rtl/traffic_phase_ctrl.sv | 144 ++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_ctrl.sv
// Phase sequencer for a two-direction traffic light driving 5 s / 10 s interval counters.
// Optional macro TL_YELLOW_BLINK_EN: yellow lamp bit follows clk_halfs in yellow phases.
module traffic_phase_ctrl #(
  parameter int GREEN_SECS  = 10,
  parameter int YELLOW_SECS = 5,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_1s,
  input  logic             clk_halfs,
  input  logic             cnt_out_5s,
  input  logic             cnt_out_10s,
  output logic             en_cnt_5s,
  output logic             en_cnt_10s,
  output logic [2:0]       ns_light,
  output logic [2:0]       ew_light,
  output logic [CNT_W-1:0] countdown,
  output logic [2:0]       phase
);

  typedef enum logic [2:0] {
    INIT      = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_SECS);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_SECS);

  state_t           state_q, state_d, nxt;
  logic             gap_q, gap_d;
  logic             en5_q, en5_d;
  logic             en10_q, en10_d;
  logic [CNT_W-1:0] cd_q, cd_d;
  logic [2:0]       ns_q, ns_d;
  logic [2:0]       ew_q, ew_d;
  logic             tick_q, c5_q, c10_q;
  logic             tick_rise, c5_rise, c10_rise;
  logic             is_green, sel_rise, sel_en, enter;

  assign tick_rise = tick_1s & ~tick_q;
  assign c5_rise   = cnt_out_5s & ~c5_q;
  assign c10_rise  = cnt_out_10s & ~c10_q;

  function automatic logic [5:0] lamps(input state_t s);
    logic [5:0] l;
    l = {3'b100, 3'b100};
    unique case (1'b1)
      (s == NS_GREEN):  l = {3'b001, 3'b100};
      (s == NS_YELLOW): l = {3'b010, 3'b100};
      (s == EW_GREEN):  l = {3'b100, 3'b001};
      (s == EW_YELLOW): l = {3'b100, 3'b010};
      default:          l = {3'b100, 3'b100};
    endcase
    return l;
  endfunction

  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    en5_d    = en5_q;
    en10_d   = en10_q;
    cd_d     = cd_q;
    ns_d     = ns_q;
    ew_d     = ew_q;
    enter    = 1'b0;
    nxt      = INIT;
    is_green = (state_q == NS_GREEN) || (state_q == EW_GREEN);
    sel_rise = is_green ? c10_rise : c5_rise;
    sel_en   = is_green ? en10_q : en5_q;
    unique case (1'b1)
      (state_q == INIT):      nxt = NS_GREEN;
      (state_q == NS_GREEN):  nxt = NS_YELLOW;
      (state_q == NS_YELLOW): nxt = EW_GREEN;
      (state_q == EW_GREEN):  nxt = EW_YELLOW;
      (state_q == EW_YELLOW): nxt = NS_GREEN;
      default:                nxt = INIT;
    endcase
    if (state_q == INIT) begin
      enter = 1'b1;
    end else if (!gap_q && sel_en && sel_rise) begin
      enter = 1'b1;
    end
    if (enter) begin
      state_d = nxt;
      gap_d   = 1'b1;
      en5_d   = 1'b0;
      en10_d  = 1'b0;
      cd_d    = (nxt == NS_GREEN || nxt == EW_GREEN) ? GREEN_LD : YELLOW_LD;
      {ns_d, ew_d} = lamps(nxt);
    end else begin
      if (gap_q) begin
        gap_d  = 1'b0;
        en10_d = is_green;
        en5_d  = ~is_green;
      end
      // reload above takes priority over a same-cycle tick
      if (tick_rise && cd_q != '0) cd_d = cd_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      gap_q   <= 1'b1;
      en5_q   <= 1'b0;
      en10_q  <= 1'b0;
      cd_q    <= '0;
      ns_q    <= 3'b100;
      ew_q    <= 3'b100;
      tick_q  <= 1'b0;
      c5_q    <= 1'b0;
      c10_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      en5_q   <= en5_d;
      en10_q  <= en10_d;
      cd_q    <= cd_d;
      ns_q    <= ns_d;
      ew_q    <= ew_d;
      tick_q  <= tick_1s;
      c5_q    <= cnt_out_5s;
      c10_q   <= cnt_out_10s;
    end
  end

  assign en_cnt_5s  = en5_q;
  assign en_cnt_10s = en10_q;
  assign countdown  = cd_q;
  assign phase      = state_q;

`ifdef TL_YELLOW_BLINK_EN
  assign ns_light = {ns_q[2], ns_q[1] & clk_halfs, ns_q[0]};
  assign ew_light = {ew_q[2], ew_q[1] & clk_halfs, ew_q[0]};
`else
  assign ns_light = ns_q;
  assign ew_light = ew_q;
`endif

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: counter/tick environment, spec-level model, directed scenarios.
// One simulated "second" is 8 clock cycles to keep the run short.
module tb_traffic_phase_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       man_tick = 1'b0;
  logic       spur5 = 1'b0;
  logic       spur10 = 1'b0;
  logic       auto_en = 1'b1;
  logic [2:0] tcnt = 3'd0;
  logic       tick_1s, clk_halfs, cnt_out_5s, cnt_out_10s;
  logic       en_cnt_5s, en_cnt_10s;
  logic [2:0] ns_light, ew_light, phase;
  logic [3:0] countdown;

  int   c5 = 0, c10 = 0, cyc = 0;
  logic d5 = 1'b0, d10 = 1'b0, etp = 1'b0;
  int   checks = 0, errors = 0;

  traffic_phase_ctrl dut (
    .clk(clk), .rst_n(rst_n), .tick_1s(tick_1s), .clk_halfs(clk_halfs),
    .cnt_out_5s(cnt_out_5s), .cnt_out_10s(cnt_out_10s),
    .en_cnt_5s(en_cnt_5s), .en_cnt_10s(en_cnt_10s),
    .ns_light(ns_light), .ew_light(ew_light),
    .countdown(countdown), .phase(phase)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tcnt <= tcnt + 3'd1;
    cyc  <= cyc + 1;
  end

  assign tick_1s     = (auto_en && tcnt == 3'd7) || man_tick;
  assign clk_halfs   = tcnt[2];
  assign cnt_out_5s  = d5 | spur5;
  assign cnt_out_10s = d10 | spur10;

  // Interval counters: count seconds while enabled, restart when disabled
  always @(posedge clk) begin
    etp <= tick_1s;
    if (!en_cnt_10s) begin
      c10 <= 0;
      d10 <= 1'b0;
    end else if (tick_1s && !etp) begin
      c10 <= c10 + 1;
      if (c10 == 9) d10 <= 1'b1;
    end
    if (!en_cnt_5s) begin
      c5 <= 0;
      d5 <= 1'b0;
    end else if (tick_1s && !etp) begin
      c5 <= c5 + 1;
      if (c5 == 4) d5 <= 1'b1;
    end
  end

  // Reference model: phase number, in-gap flag, seconds remaining
  int m_ph = 0, m_secs = 0;
  bit m_gap = 1'b1;
  bit p_t = 1'b0, p_5 = 1'b0, p_10 = 1'b0;
  bit tr, r5, r10, dn;

  task automatic m_enter(input int p);
    m_ph   = p;
    m_gap  = 1'b1;
    m_secs = (p % 2 == 1) ? 10 : 5;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_ph = 0; m_gap = 1'b1; m_secs = 0;
      p_t = 1'b0; p_5 = 1'b0; p_10 = 1'b0;
    end else begin
      tr  = tick_1s && !p_t;
      r5  = cnt_out_5s && !p_5;
      r10 = cnt_out_10s && !p_10;
      if (m_ph == 0) begin
        m_enter(1);
      end else begin
        dn = (m_ph % 2 == 1) ? r10 : r5;
        if (!m_gap && dn) begin
          m_enter(m_ph == 4 ? 1 : m_ph + 1);
        end else begin
          m_gap = 1'b0;
          if (tr && m_secs > 0) m_secs = m_secs - 1;
        end
      end
      p_t = tick_1s; p_5 = cnt_out_5s; p_10 = cnt_out_10s;
    end
  end

  function automatic logic [2:0] exp_lamp(input int p, input bit ns, input bit yb);
    if (ns) begin
      if (p == 1) return 3'b001;
      if (p == 2) return {1'b0, yb, 1'b0};
      return 3'b100;
    end
    if (p == 3) return 3'b001;
    if (p == 4) return {1'b0, yb, 1'b0};
    return 3'b100;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the model
  bit yb;
  initial forever begin
    @(posedge clk);
    #1;
`ifdef TL_YELLOW_BLINK_EN
    yb = clk_halfs;
`else
    yb = 1'b1;
`endif
    check("phase", phase, m_ph);
    check("countdown", countdown, m_secs);
    check("en_10s", en_cnt_10s, (!m_gap && (m_ph == 1 || m_ph == 3)) ? 1 : 0);
    check("en_5s", en_cnt_5s, (!m_gap && (m_ph == 2 || m_ph == 4)) ? 1 : 0);
    check("ns_light", ns_light, exp_lamp(m_ph, 1'b1, yb));
    check("ew_light", ew_light, exp_lamp(m_ph, 1'b0, yb));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_phase(input int p, output int t);
    int n = 0;
    while (phase != 3'(p) && n < 600) begin
      step();
      n++;
    end
    t = cyc;
    check("wait_phase", phase, p);
  endtask

  int t1, t2, t3, t4, lo, hi, n;

  initial begin
    rst_n = 1'b0;
    repeat (3) begin
      step();
      check("rst_phase", phase, 0);
      check("rst_ns", ns_light, 3'b100);
      check("rst_ew", ew_light, 3'b100);
      check("rst_en", {en_cnt_5s, en_cnt_10s}, 0);
    end
    #1 rst_n = 1'b1;
    step();
    check("init_phase", phase, 1);
    check("init_cd", countdown, 10);
    check("init_gap_en", en_cnt_10s, 0);
    step();
    check("init_en10", en_cnt_10s, 1);

    // Full cycle with durations in cycles (8 per second)
    wait_phase(2, t2);
    check("ns_yellow_load", countdown, 5);
    wait_phase(3, t3);
    check("dur_ns_yellow", t3 - t2, 40);
    wait_phase(4, t4);
    check("dur_ew_green", t4 - t3, 80);
    wait_phase(1, t1);
    check("dur_ew_yellow", t1 - t4, 40);
    check("green_reload", countdown, 10);

    // Unselected counter done during NS_GREEN
    repeat (5) step();
    spur5 = 1'b1;
    step();
    spur5 = 1'b0;
    step();
    check("spur5_phase", phase, 1);
    wait_phase(2, t2);
    check("dur_ns_green", t2 - t1, 80);

    // Selected counter done during the EW_GREEN gap cycle
    wait_phase(3, t3);
    spur10 = 1'b1;
    step();
    spur10 = 1'b0;
    check("spur10_phase", phase, 3);
    check("spur10_en", en_cnt_10s, 1);
    step();
    check("spur10_phase2", phase, 3);

    // Tick and done edge in the same cycle
    wait_phase(4, t4);
    wait_phase(1, t1);
    auto_en = 1'b0;
    repeat (3) step();
    man_tick = 1'b1;
    spur10 = 1'b1;
    step();
    man_tick = 1'b0;
    spur10 = 1'b0;
    check("collide_phase", phase, 2);
    check("collide_cd", countdown, 5);
    auto_en = 1'b1;

    // Asynchronous reset in EW_YELLOW at countdown 3
    wait_phase(4, t4);
    n = 0;
    while (countdown != 4'd3 && n < 100) begin
      step();
      n++;
    end
    check("pre_rst_cd", countdown, 3);
    #1 rst_n = 1'b0;
    #1;
    check("arst_phase", phase, 0);
    check("arst_cd", countdown, 0);
    check("arst_ns", ns_light, 3'b100);
    check("arst_ew", ew_light, 3'b100);
    check("arst_en", {en_cnt_5s, en_cnt_10s}, 0);
    step();
    #1 rst_n = 1'b1;
    step();
    check("restart_phase", phase, 1);
    check("restart_cd", countdown, 10);
    step();
    check("restart_en10", en_cnt_10s, 1);

    // Yellow lamp behaviour over a whole NS_YELLOW phase
    wait_phase(2, t2);
    lo = 0;
    hi = 0;
    n = 0;
    while (phase == 3'd2 && n < 200) begin
      if (ns_light[1]) hi++;
      else lo++;
      step();
      n++;
    end
`ifdef TL_YELLOW_BLINK_EN
    check("blink_lo_seen", (lo > 0) ? 1 : 0, 1);
    check("blink_hi_seen", (hi > 0) ? 1 : 0, 1);
`else
    check("yellow_steady", lo, 0);
    check("yellow_len", hi, 40);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
